// File: rtl/uart_dbg_tx.sv
// Buffered 8N1 UART transmitter for the debug serial line.
// A small circular FIFO decouples the core's byte pushes from the serial frame timing.
module uart_dbg_tx #(
  parameter int BAUD_DIV   = 2604,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       fifo_full
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(BAUD_DIV);

  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);
  localparam logic [CNTW-1:0] CNT_ZERO  = {CNTW{1'b0}};
  localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]   BAUD_ZERO = {CW{1'b0}};
  localparam logic [3:0]      BIT_STOP  = 4'd9;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TXING = 1'b1
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [7:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNTW-1:0] count_r, count_nxt_s;
  logic [9:0]      shreg_r, shreg_nxt_s;
  logic [CW-1:0]   baud_cnt_r, baud_nxt_s;
  logic [3:0]      bit_cnt_r, bit_nxt_s;
  logic            tx_r, done_r, busy_r, full_r;
  logic            push_s, pop_s, done_nxt_s, tx_nxt_s;

  // Push uses the registered count, so a push while full is dropped even when a pop coincides.
  assign push_s = trmt && (count_r != CNT_FULL);

  // Frame sequencer: pops a byte in IDLE, then times ten bit periods.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    baud_nxt_s  = baud_cnt_r;
    bit_nxt_s   = bit_cnt_r;
    pop_s       = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (count_r != CNT_ZERO) begin
          pop_s       = 1'b1;
          shreg_nxt_s = {1'b1, fifo_mem_r[rd_ptr_r], 1'b0};
          baud_nxt_s  = BAUD_ZERO;
          bit_nxt_s   = 4'd0;
          state_nxt_s = ST_TXING;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TXING: begin
        if (baud_cnt_r == BAUD_LAST) begin
          baud_nxt_s = BAUD_ZERO;
          if (bit_cnt_r == BIT_STOP) begin
            bit_nxt_s   = 4'd0;
            shreg_nxt_s = 10'h3FF;
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            bit_nxt_s   = bit_cnt_r + 4'd1;
            shreg_nxt_s = {1'b1, shreg_r[9:1]};
          end
        end else begin
          baud_nxt_s = baud_cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        shreg_nxt_s = 10'h3FF;
        baud_nxt_s  = BAUD_ZERO;
        bit_nxt_s   = 4'd0;
      end
    endcase
  end

  // Occupancy update for simultaneous push and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNTW'(1);
      2'b01:   count_nxt_s = count_r - CNTW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // The line is driven from a register; idle and reset both hold it high.
  always_comb begin
    if (state_nxt_s == ST_TXING) begin
      tx_nxt_s = shreg_nxt_s[0];
    end else begin
      tx_nxt_s = 1'b1;
    end
  end

  // FSM, shift register and bit timing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      shreg_r    <= 10'h3FF;
      baud_cnt_r <= BAUD_ZERO;
      bit_cnt_r  <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      shreg_r    <= shreg_nxt_s;
      baud_cnt_r <= baud_nxt_s;
      bit_cnt_r  <= bit_nxt_s;
    end
  end

  // FIFO storage and pointers; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= tx_data;
        wr_ptr_r             <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Output registers track the next-state values so they match the current state each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r   <= 1'b1;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      full_r <= 1'b0;
    end else begin
      tx_r   <= tx_nxt_s;
      done_r <= done_nxt_s;
      busy_r <= (state_nxt_s == ST_TXING) || (count_nxt_s != CNT_ZERO);
      full_r <= (count_nxt_s == CNT_FULL);
    end
  end

  assign TX        = tx_r;
  assign tx_done   = done_r;
  assign tx_busy   = busy_r;
  assign fifo_full = full_r;

endmodule

// File: tb/tb_uart_dbg_tx.sv
// Scoreboard bench for uart_dbg_tx: directed pushes queue expected bytes,
// a line monitor decodes frames off TX and checks bit timing and tx_done.
module tb_uart_dbg_tx;

  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trmt = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TX, tx_done, tx_busy, fifo_full;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         mon_ph = -1;
  logic       prev_done = 1'b0;
  logic [7:0] mon_byte = 8'h00;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_dbg_tx #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data),
    .TX(TX), .tx_done(tx_done), .tx_busy(tx_busy), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Called on a negedge; the byte is sampled on the following posedge.
  task automatic push(input logic [7:0] d, input bit accepted);
    trmt = 1'b1;
    tx_data = d;
    if (accepted) exp_q.push_back(d);
    @(negedge clk);
    trmt = 1'b0;
    tx_data = 8'hEE;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy !== 1'b0 || mon_ph >= 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_phase(input int ph, input int budget);
    int n;
    n = 0;
    while (mon_ph < ph && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("phase_timeout", 32'(n < budget), 32'd1);
  endtask

  // Line monitor: frame phase 0 is the first cycle of the start bit.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_ph = -1;
        prev_done = 1'b0;
      end else begin
        if (mon_ph < 0) begin
          if (TX === 1'b0) begin
            mon_ph = 0;
            mon_byte = 8'h00;
            start_q.push_back(cyc);
          end
        end else begin
          mon_ph++;
        end
        if (tx_done === 1'b1) begin
          done_cnt++;
          chk("done_single_cycle", 32'(prev_done), 32'd0);
          chk("done_position", mon_ph, 10 * BD);
        end
        prev_done = tx_done;
        if (mon_ph == BD / 2) begin
          chk("start_bit", 32'(TX), 32'd0);
        end else if (mon_ph > BD / 2 && mon_ph < 9 * BD && (mon_ph % BD) == BD / 2) begin
          mon_byte[mon_ph / BD - 1] = TX;
        end else if (mon_ph == 9 * BD + BD / 2) begin
          chk("stop_bit", 32'(TX), 32'd1);
        end else if (mon_ph == 10 * BD) begin
          chk("done_at_frame_end", 32'(tx_done), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got %02h expected no frame", mon_byte);
          end else begin
            chk("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
          end
          mon_ph = -1;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int base, t0, d0, sc;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_TX", 32'(TX), 32'd1);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy), 32'd0);
    chk("rst_fifo_full", 32'(fifo_full), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5: start visible one cycle after the push edge's following edge
    base = start_q.size();
    d0 = done_cnt;
    t0 = cyc + 1;
    push(8'hA5, 1'b1);
    chk("busy_after_push", 32'(tx_busy), 32'd1);
    wait_idle(400);
    chk("a5_frames", start_q.size(), base + 1);
    if (start_q.size() > base) chk("a5_start_latency", start_q[base], t0 + 1);
    chk("a5_done_count", done_cnt - d0, 1);
    chk("a5_busy_after", 32'(tx_busy), 32'd0);

    // Burst of four: FIFO never fills because the first pop overlaps the pushes
    base = start_q.size();
    d0 = done_cnt;
    push(8'h01, 1'b1);
    push(8'h02, 1'b1);
    push(8'h03, 1'b1);
    push(8'h04, 1'b1);
    chk("burst_not_full", 32'(fifo_full), 32'd0);
    wait_idle(1200);
    chk("burst_frames", start_q.size(), base + 4);
    if (start_q.size() >= base + 4) begin
      for (int i = 1; i < 4; i++) begin
        chk("burst_pitch", start_q[base + i] - start_q[base + i - 1], 10 * BD + 1);
      end
    end
    chk("burst_done_count", done_cnt - d0, 4);

    // Overflow: 0x55 pushed while full is dropped
    push(8'h00, 1'b1);
    push(8'h11, 1'b1);
    push(8'h22, 1'b1);
    push(8'h33, 1'b1);
    push(8'h44, 1'b1);
    chk("ovf_full", 32'(fifo_full), 32'd1);
    push(8'h55, 1'b0);
    chk("ovf_still_full", 32'(fifo_full), 32'd1);
    wait_idle(1500);

    // Push while full in the pop cycle is dropped; count goes 4 -> 3
    push(8'h00, 1'b1);
    push(8'h66, 1'b1);
    push(8'h77, 1'b1);
    push(8'h88, 1'b1);
    push(8'hCC, 1'b1);
    chk("popcyc_full", 32'(fifo_full), 32'd1);
    t0 = 0;
    while (tx_done !== 1'b1 && t0 < 400) begin
      @(negedge clk);
      t0++;
    end
    chk("popcyc_done_seen", 32'(tx_done), 32'd1);
    push(8'h99, 1'b0);
    chk("popcyc_not_full", 32'(fifo_full), 32'd0);
    chk("popcyc_busy", 32'(tx_busy), 32'd1);
    wait_idle(1500);

    // Reset during bit 4 of 0xFF with two bytes queued
    base = start_q.size();
    push(8'hFF, 1'b1);
    push(8'h12, 1'b1);
    push(8'h34, 1'b1);
    wait_phase(4 * BD + 6, 200);
    d0 = done_cnt;
    sc = start_q.size();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_TX", 32'(TX), 32'd1);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_full", 32'(fifo_full), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_frames", start_q.size(), sc);
    chk("mid_rst_idle_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_idle_TX", 32'(TX), 32'd1);

    // Reset while a 0 data bit is on the line must raise TX without a clock edge
    push(8'h00, 1'b1);
    wait_phase(BD + BD / 2, 200);
    chk("zero_bit_low", 32'(TX), 32'd0);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_TX", 32'(TX), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("async_rst_no_done", done_cnt - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
